// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing constants for the VGA raster generator.
package vga_timing_pkg;

   typedef enum logic [1:0] {H_ACT, H_FP, H_SP, H_BP} h_phase_t;
   typedef enum logic [1:0] {V_ACT, V_FP, V_SP, V_BP} v_phase_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;
   localparam int DEF_CLK_DIV  = 2;

   function automatic int calc_total(input int active, input int front,
                                     input int sync, input int back);
      return active + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_clk_div.sv
// Pixel-rate divider: one-Clk pix_en strobe on the last Clk of each pixel and a
// registered 50% duty VGA_CLK that rises mid-pixel.
module vga_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic Clk,
   input  logic Reset_n,
   output logic pix_en,
   output logic VGA_CLK
);

   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0] div_cnt;
   logic [CW-1:0] div_nxt;

   always_comb begin
      div_nxt = (div_cnt == CW'(CLK_DIV - 1)) ? '0 : div_cnt + CW'(1);
   end

   // VGA_CLK is decoded from the next count so it lines up with div_cnt itself
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         div_cnt <= '0;
         VGA_CLK <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         VGA_CLK <= (div_nxt >= CW'(CLK_DIV / 2));
      end
   end

   assign pix_en = (div_cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel counters, horizontal/vertical phase FSMs and sync/blank decode.
// Define VGA_TIMING_OUT_DELAY_EN to delay VGA_HS/VGA_VS/VGA_BLANK_N by one pixel.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter int CLK_DIV  = DEF_CLK_DIV
) (
   input  logic       Clk,
   input  logic       Reset_n,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       pix_en,
   output logic       line_start,
   output logic       frame_start
);

   localparam int H_TOTAL = calc_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = calc_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

   if (H_TOTAL > 1024) begin : g_h_total_chk
      $error("vga_timing_gen: H_TOTAL exceeds 1024");
   end
   if (V_TOTAL > 1024) begin : g_v_total_chk
      $error("vga_timing_gen: V_TOTAL exceeds 1024");
   end
   if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_div_chk
      $error("vga_timing_gen: CLK_DIV must be even and >= 2");
   end

   vga_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .pix_en  (pix_en),
      .VGA_CLK (VGA_CLK)
   );

   logic [9:0] hc, vc;
   logic [9:0] hc_nxt, vc_nxt;
   logic       h_wrap, v_wrap;
   h_phase_t   h_state, h_nxt;
   v_phase_t   v_state, v_nxt;
   logic       hs_p0, vs_p0, blank_p0;

   // Stage 0: next counter values and next phases, all decided on the pix_en edge
   always_comb begin
      h_wrap = pix_en && (hc == 10'(H_TOTAL - 1));
      v_wrap = h_wrap && (vc == 10'(V_TOTAL - 1));
      hc_nxt = hc;
      vc_nxt = vc;
      if (pix_en) hc_nxt = h_wrap ? '0 : hc + 10'd1;
      if (h_wrap) vc_nxt = v_wrap ? '0 : vc + 10'd1;

      h_nxt = h_state;
      if (pix_en) begin
         case (h_state)
            H_ACT:   if (hc_nxt == 10'(H_ACTIVE))                    h_nxt = H_FP;
            H_FP:    if (hc_nxt == 10'(H_ACTIVE + H_FRONT))          h_nxt = H_SP;
            H_SP:    if (hc_nxt == 10'(H_ACTIVE + H_FRONT + H_SYNC)) h_nxt = H_BP;
            H_BP:    if (hc_nxt == '0)                               h_nxt = H_ACT;
            default: h_nxt = H_ACT;
         endcase
      end

      v_nxt = v_state;
      if (h_wrap) begin
         case (v_state)
            V_ACT:   if (vc_nxt == 10'(V_ACTIVE))                    v_nxt = V_FP;
            V_FP:    if (vc_nxt == 10'(V_ACTIVE + V_FRONT))          v_nxt = V_SP;
            V_SP:    if (vc_nxt == 10'(V_ACTIVE + V_FRONT + V_SYNC)) v_nxt = V_BP;
            V_BP:    if (vc_nxt == '0)                               v_nxt = V_ACT;
            default: v_nxt = V_ACT;
         endcase
      end
   end

   // Stage p0: counters, phases and decoded outputs all load on the same edge
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hc          <= '0;
         vc          <= '0;
         h_state     <= H_ACT;
         v_state     <= V_ACT;
         hs_p0       <= 1'b1;
         vs_p0       <= 1'b1;
         blank_p0    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hc          <= hc_nxt;
         vc          <= vc_nxt;
         h_state     <= h_nxt;
         v_state     <= v_nxt;
         hs_p0       <= (h_nxt != H_SP);
         vs_p0       <= (v_nxt != V_SP);
         blank_p0    <= (h_nxt == H_ACT) && (v_nxt == V_ACT);
         line_start  <= h_wrap;
         frame_start <= v_wrap;
      end
   end

`ifdef VGA_TIMING_OUT_DELAY_EN
   logic hs_p1, vs_p1, blank_p1;

   // Stage p1: one-pixel delay to match a registered sprite-ROM colour lookup
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hs_p1    <= 1'b1;
         vs_p1    <= 1'b1;
         blank_p1 <= 1'b0;
      end else if (pix_en) begin
         hs_p1    <= hs_p0;
         vs_p1    <= vs_p0;
         blank_p1 <= blank_p0;
      end
   end

   assign VGA_HS      = hs_p1;
   assign VGA_VS      = vs_p1;
   assign VGA_BLANK_N = blank_p1;
`else
   assign VGA_HS      = hs_p0;
   assign VGA_VS      = vs_p0;
   assign VGA_BLANK_N = blank_p0;
`endif

   assign DrawX      = hc;
   assign DrawY      = vc;
   assign VGA_SYNC_N = 1'b0;

endmodule
